// File: rtl/vend_controller.sv
// Vending transaction controller: accumulates coin credit, runs the dispenser req/ack
// handshake, then pays change one rupee per cycle. Cancel and inactivity both refund.
module vend_controller #(
  parameter int PRICE_A    = 3,
  parameter int PRICE_B    = 5,
  parameter int MAX_CREDIT = 15,
  parameter int CREDIT_W   = 4,
  parameter int TIMEOUT    = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin_in,
  input  logic [1:0]          sel,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic                disp_item,
  output logic                change_out,
  output logic                coin_reject,
  output logic                low_credit,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam logic [CREDIT_W-1:0] PRICE_A_C  = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PRICE_B_C  = CREDIT_W'(PRICE_B);
  localparam logic [CREDIT_W:0]   MAX_C      = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [TO_W-1:0]     TO_LAST    = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_DISPENSE,
    S_CHANGE
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'b00,
    SEL_A      = 2'b01,
    SEL_B      = 2'b10,
    SEL_CANCEL = 2'b11
  } sel_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                disp_req_q, disp_req_d;
  logic                disp_item_q, disp_item_d;
  logic                change_q, change_d;
  logic                reject_q, reject_d;
  logic                low_q, low_d;
  logic                busy_q, busy_d;

  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_valid;
  logic                sel_product;
  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W-1:0] item_price;
  logic [CREDIT_W-1:0] remainder;

  always_comb begin
    coin_val = '0;
    case (coin_in)
      2'b01:   coin_val = (CREDIT_W + 1)'(1);
      2'b10:   coin_val = (CREDIT_W + 1)'(2);
      2'b11:   coin_val = (CREDIT_W + 1)'(5);
      default: coin_val = '0;
    endcase
  end

  // One extra bit so an over-limit sum is detected instead of wrapping.
  assign coin_sum    = {1'b0, credit_q} + coin_val;
  assign coin_valid  = (coin_in != 2'b00);
  assign sel_product = (sel == SEL_A) || (sel == SEL_B);
  assign sel_price   = (sel == SEL_B) ? PRICE_B_C : PRICE_A_C;
  assign item_price  = disp_item_q ? PRICE_B_C : PRICE_A_C;
  assign remainder   = credit_q - item_price;

  // NOTE: every variable assigned here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    to_cnt_d    = '0;
    disp_req_d  = disp_req_q;
    disp_item_d = disp_item_q;
    change_d    = 1'b0;
    reject_d    = 1'b0;
    low_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        credit_d = '0;
        // A coin wins over a selection made in the same cycle.
        if (coin_valid) begin
          credit_d = coin_val[CREDIT_W-1:0];
          state_d  = S_CREDIT;
        end else if (sel_product) begin
          low_d = 1'b1;
        end
      end

      S_CREDIT: begin
        if (coin_valid) begin
          if (coin_sum <= MAX_C) credit_d = coin_sum[CREDIT_W-1:0];
          else                   reject_d = 1'b1;
        end else if (sel_product) begin
          if (credit_q >= sel_price) begin
            state_d     = S_DISPENSE;
            disp_req_d  = 1'b1;
            disp_item_d = (sel == SEL_B);
          end else begin
            low_d = 1'b1;
          end
        end else if (sel == SEL_CANCEL) begin
          state_d = S_CHANGE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_CHANGE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_DISPENSE: begin
        reject_d = coin_valid;
        if (disp_ack && disp_req_q) begin
          credit_d   = remainder;
          disp_req_d = 1'b0;
          state_d    = (remainder != '0) ? S_CHANGE : S_IDLE;
        end
      end

      S_CHANGE: begin
        reject_d = coin_valid;
        change_d = 1'b1;
        credit_d = credit_q - CREDIT_W'(1);
        if (credit_q <= CREDIT_W'(1)) begin
          credit_d = '0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        credit_d   = '0;
        disp_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d == S_DISPENSE) || (state_d == S_CHANGE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      credit_q    <= '0;
      to_cnt_q    <= '0;
      disp_req_q  <= 1'b0;
      disp_item_q <= 1'b0;
      change_q    <= 1'b0;
      reject_q    <= 1'b0;
      low_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      to_cnt_q    <= to_cnt_d;
      disp_req_q  <= disp_req_d;
      disp_item_q <= disp_item_d;
      change_q    <= change_d;
      reject_q    <= reject_d;
      low_q       <= low_d;
      busy_q      <= busy_d;
    end
  end

  assign disp_req    = disp_req_q;
  assign disp_item   = disp_item_q;
  assign change_out  = change_q;
  assign coin_reject = reject_q;
  assign low_credit  = low_q;
  assign credit      = credit_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed vector table, hand-written timeout/reset sequences,
// then random traffic compared cycle by cycle against a transaction-level model.
module tb_vend_controller;

  localparam int PRICE_A    = 3;
  localparam int PRICE_B    = 5;
  localparam int MAX_CREDIT = 15;
  localparam int CREDIT_W   = 4;
  localparam int TIMEOUT    = 200;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          coin_in = '0;
  logic [1:0]          sel = '0;
  logic                disp_ack = 1'b0;
  logic                disp_req, disp_item, change_out, coin_reject, low_credit, busy;
  logic [CREDIT_W-1:0] credit;

  int n_checks = 0;
  int n_fail   = 0;

  vend_controller #(
    .PRICE_A(PRICE_A), .PRICE_B(PRICE_B), .MAX_CREDIT(MAX_CREDIT),
    .CREDIT_W(CREDIT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .coin_in(coin_in), .sel(sel), .disp_ack(disp_ack),
    .disp_req(disp_req), .disp_item(disp_item), .change_out(change_out),
    .coin_reject(coin_reject), .low_credit(low_credit), .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  // Output bundle: {credit[3:0], req, item(valid only with req), change, reject, low, busy}
  typedef struct {
    logic [1:0] coin;
    logic [1:0] sel;
    logic       ack;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [9:0] pack(int cr, bit req, bit it, bit ch, bit rj, bit lo, bit bz);
    return {4'(cr), req, it & req, ch, rj, lo, bz};
  endfunction

  function automatic logic [9:0] outs();
    return {credit, disp_req, disp_item & disp_req, change_out, coin_reject, low_credit, busy};
  endfunction

  task automatic add(input logic [1:0] c, input logic [1:0] s, input logic a,
                     input int cr, input bit req, input bit it, input bit ch,
                     input bit rj, input bit lo, input bit bz);
    vec_t v;
    v.coin = c; v.sel = s; v.ack = a;
    v.exp  = pack(cr, req, it, ch, rj, lo, bz);
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
  task automatic step(input logic [1:0] c, input logic [1:0] s, input logic a);
    coin_in  = c;
    sel      = s;
    disp_ack = a;
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: credit held, product pending, refund in progress, idle count.
  int m_credit, m_item, m_idle;
  bit m_paying;

  task automatic model_reset();
    m_credit = 0; m_item = -1; m_idle = 0; m_paying = 0;
  endtask

  task automatic model_step(input logic [1:0] c, input logic [1:0] s, input logic a,
                            output logic [9:0] e);
    int v;
    bit chg, rej, low;
    chg = 0; rej = 0; low = 0;
    v = (c == 2'd1) ? 1 : (c == 2'd2) ? 2 : (c == 2'd3) ? 5 : 0;
    if (m_paying) begin
      rej = (c != 0);
      chg = 1;
      m_credit--;
      if (m_credit == 0) m_paying = 0;
    end else if (m_item >= 0) begin
      rej = (c != 0);
      if (a) begin
        m_credit -= (m_item == 1) ? PRICE_B : PRICE_A;
        m_item    = -1;
        m_paying  = (m_credit > 0);
      end
    end else if (m_credit == 0) begin
      if (c != 0) begin
        m_credit = v;
        m_idle   = 0;
      end else if (s == 2'd1 || s == 2'd2) begin
        low = 1;
      end
    end else begin
      if (c != 0) begin
        m_idle = 0;
        if (m_credit + v <= MAX_CREDIT) m_credit += v;
        else rej = 1;
      end else if (s == 2'd1 || s == 2'd2) begin
        m_idle = 0;
        if (m_credit >= ((s == 2'd2) ? PRICE_B : PRICE_A)) m_item = (s == 2'd2) ? 1 : 0;
        else low = 1;
      end else if (s == 2'd3) begin
        m_idle   = 0;
        m_paying = 1;
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_idle   = 0;
          m_paying = 1;
        end
      end
    end
    e = pack(m_credit, m_item >= 0, m_item == 1, chg, rej, low, m_paying || m_item >= 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    logic [9:0] e;
    logic [1:0] c, s;
    logic a;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 10'h0);
    rst = 1'b1;

    // ---- directed table ----
    // coins 1,2 then product A with a held-off ack; coin and sel in DISPENSE are refused/ignored
    add(1, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(2, 0, 0,  3, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0,  3, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0,  3, 1, 0, 0, 0, 0, 1);
    add(3, 0, 0,  3, 1, 0, 0, 1, 0, 1);
    add(0, 2, 0,  3, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0,  3, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    // fill to MAX_CREDIT, over-limit coins rejected, product B, 10 rupees change
    add(3, 0, 0,  5, 0, 0, 0, 0, 0, 0);
    add(3, 0, 0, 10, 0, 0, 0, 0, 0, 0);
    add(3, 0, 0, 15, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 15, 0, 0, 0, 1, 0, 0);
    add(2, 0, 0, 15, 0, 0, 0, 1, 0, 0);
    add(0, 2, 0, 15, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 15, 1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 10, 0, 0, 0, 0, 0, 1);
    for (int k = 9; k >= 0; k--) add(0, 0, 0, k, 0, 0, 1, 0, 0, k != 0);
    add(0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    // low credit for B and A, then cancel with a coin refused during CHANGE
    add(2, 0, 0,  2, 0, 0, 0, 0, 0, 0);
    add(0, 2, 0,  2, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0,  2, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0,  2, 0, 0, 0, 0, 0, 0);
    add(0, 3, 0,  2, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0,  1, 0, 0, 1, 1, 0, 1);
    add(0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    // selection in IDLE, exact-price purchase of B with no change
    add(0, 1, 0,  0, 0, 0, 0, 0, 1, 0);
    add(3, 0, 0,  5, 0, 0, 0, 0, 0, 0);
    add(0, 2, 0,  5, 1, 1, 0, 0, 0, 1);
    add(0, 0, 1,  0, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].coin, tbl[i].sel, tbl[i].ack);
      check($sformatf("vec_%0d", i), outs(), tbl[i].exp);
    end

    // ---- inactivity timeout with 1 rupee ----
    step(1, 0, 0);
    check("to_coin", outs(), pack(1, 0, 0, 0, 0, 0, 0));
    bad = 0;
    repeat (TIMEOUT - 1) begin
      step(0, 0, 0);
      if (outs() !== pack(1, 0, 0, 0, 0, 0, 0)) bad++;
    end
    check("to_wait_cycles_bad", bad, 0);
    step(0, 0, 0);
    check("to_enter_change", outs(), pack(1, 0, 0, 0, 0, 0, 1));
    step(0, 0, 0);
    check("to_refund_pulse", outs(), pack(0, 0, 0, 1, 0, 0, 0));
    step(0, 0, 0);
    check("to_back_idle", outs(), pack(0, 0, 0, 0, 0, 0, 0));

    // ---- coin at cycle TIMEOUT-1 restarts the count ----
    step(1, 0, 0);
    repeat (TIMEOUT - 2) step(0, 0, 0);
    step(1, 0, 0);
    check("rs_coin", outs(), pack(2, 0, 0, 0, 0, 0, 0));
    bad = 0;
    repeat (TIMEOUT - 1) begin
      step(0, 0, 0);
      if (outs() !== pack(2, 0, 0, 0, 0, 0, 0)) bad++;
    end
    check("rs_wait_cycles_bad", bad, 0);
    step(0, 0, 0);
    check("rs_enter_change", outs(), pack(2, 0, 0, 0, 0, 0, 1));
    step(0, 0, 0);
    check("rs_pulse1", outs(), pack(1, 0, 0, 1, 0, 0, 1));
    step(0, 0, 0);
    check("rs_pulse2", outs(), pack(0, 0, 0, 1, 0, 0, 0));

    // ---- asynchronous reset in the middle of DISPENSE ----
    step(3, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    check("ar_in_dispense", outs(), pack(5, 1, 0, 0, 0, 0, 1));
    #3 rst = 1'b0;
    #1;
    check("ar_cleared_async", outs(), 10'h0);
    @(posedge clk);
    #1;
    check("ar_held", outs(), 10'h0);
    rst = 1'b1;
    step(0, 0, 1);
    check("ar_ack_ignored", outs(), 10'h0);

    // ---- random traffic against the model ----
    rst = 1'b0;
    step(0, 0, 0);
    rst = 1'b1;
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 250) begin
        for (int k = 0; k < TIMEOUT + 10; k++) begin
          a = ($urandom_range(0, 99) < 30);
          step(0, 0, a);
          model_step(0, 0, a, e);
          check("rnd_idle", outs(), e);
        end
      end
      c = ($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 3)) : 2'd0;
      case ($urandom_range(0, 19))
        0, 1:    s = 2'd1;
        2, 3:    s = 2'd2;
        4:       s = 2'd3;
        default: s = 2'd0;
      endcase
      a = ($urandom_range(0, 99) < 30);
      step(c, s, a);
      model_step(c, s, a, e);
      check("rnd", outs(), e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
